// File: rtl/y_reg_file.sv
// y_reg_file: 2**ADDR_W x WIDTH register file, one write port, two async read ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module y_reg_file #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rn1,
   input  logic [ADDR_W-1:0] rn2,
   input  logic [ADDR_W-1:0] wn,
   input  logic [WIDTH-1:0]  wd,
   input  logic              w,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2
);
   localparam int N = 2**ADDR_W;
   logic [WIDTH-1:0] regs_q [N];
   logic [WIDTH-1:0] regs_d [N];
   logic             wr_en;
   assign wr_en = w && (wn != '0);
   always_comb begin
      for (int i = 0; i < N; i++)
         regs_d[i] = (rst || i == 0) ? '0 : (wr_en && wn == ADDR_W'(i)) ? wd : regs_q[i];
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         regs_q[i] <= regs_d[i];
   end
   // r0 is forced to zero on the read side so it is clean even before the first reset
`ifdef REGFILE_BYPASS_EN
   assign rd1 = (rn1 == '0) ? '0 : (!rst && wr_en && rn1 == wn) ? wd : regs_q[rn1];
   assign rd2 = (rn2 == '0) ? '0 : (!rst && wr_en && rn2 == wn) ? wd : regs_q[rn2];
`else
   assign rd1 = (rn1 == '0) ? '0 : regs_q[rn1];
   assign rd2 = (rn2 == '0) ? '0 : regs_q[rn2];
`endif
endmodule
